// File: rtl/count_seq_if.sv
// Handshake/status bundle between a run sequencer and its cascaded counter chain.
// The sequencer uses the slave view and the stimulus side uses the master view.
interface count_seq_if #(
    parameter int NREV_W = 8
);
    logic              start;
    logic              stop;
    logic              periodic;
    logic [NREV_W-1:0] nrev;
    logic              rocs;
    logic              rocl;
    logic              cnt_en;
    logic              cnt_clr;
    logic              busy;
    logic              tick;
    logic              done;
    logic [NREV_W-1:0] rev_cnt;
    logic              err;

    modport master (
        output start, stop, periodic, nrev, rocs, rocl,
        input  cnt_en, cnt_clr, busy, tick, done, rev_cnt, err
    );

    modport slave (
        input  start, stop, periodic, nrev, rocs, rocl,
        output cnt_en, cnt_clr, busy, tick, done, rev_cnt, err
    );
endinterface

// File: rtl/count_seq.sv
// Run sequencer for a cascaded counter chain: clears the chain, enables it for a
// programmed number of full revolutions, pulses done, and optionally restarts.
module count_seq #(
    parameter int NREV_W = 8
) (
    input  logic       clk,
    input  logic       clr,
    count_seq_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        RUN   = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [NREV_W:0]   ONE_W1 = (NREV_W+1)'(1);
    localparam logic [NREV_W-1:0] ONE    = NREV_W'(1);

    state_t            state_q, state_d;
    logic [NREV_W-1:0] nrev_q, nrev_d;
    logic [NREV_W-1:0] rev_cnt_q, rev_cnt_d;
    logic              per_q, per_d;
    logic              tick_q, tick_d;
    logic              err_q, err_d;
    logic              accept;
    logic              count;
    logic              last_rev;

    assign accept   = (state_q == IDLE) && bus.start && !bus.stop && (bus.nrev != '0);
    // stop outranks a simultaneous carry, so an aborted revolution is never counted
    assign count    = (state_q == RUN) && !bus.stop && bus.rocl;
    assign last_rev = (({1'b0, rev_cnt_q} + ONE_W1) == {1'b0, nrev_q});

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = CLEAR;
            CLEAR:   state_d = bus.stop ? IDLE : RUN;
            RUN: begin
                if (bus.stop)              state_d = IDLE;
                else if (count && last_rev) state_d = DONE;
            end
            DONE:    state_d = (!bus.stop && per_q) ? CLEAR : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.cnt_en  = (state_q == RUN);
        bus.cnt_clr = (state_q == CLEAR);
        bus.busy    = (state_q != IDLE);
        bus.done    = (state_q == DONE);
    end

    always_comb begin
        nrev_d    = nrev_q;
        per_d     = per_q;
        rev_cnt_d = rev_cnt_q;
        tick_d    = count;
        err_d     = err_q;
        if (accept) begin
            nrev_d = bus.nrev;
            per_d  = bus.periodic;
        end
        if (state_q == CLEAR) begin
            rev_cnt_d = '0;
        end else if (count) begin
            rev_cnt_d = rev_cnt_q + ONE;
        end
        // rocs only qualifies the carry for error detection
        if (bus.rocl && ((state_q != RUN) || !bus.rocs)) begin
            err_d = 1'b1;
        end else if (accept) begin
            err_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            nrev_q    <= '0;
            per_q     <= 1'b0;
            rev_cnt_q <= '0;
            tick_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            nrev_q    <= nrev_d;
            per_q     <= per_d;
            rev_cnt_q <= rev_cnt_d;
            tick_q    <= tick_d;
            err_q     <= err_d;
        end
    end

    assign bus.tick    = tick_q;
    assign bus.rev_cnt = rev_cnt_q;
    assign bus.err     = err_q;
endmodule
